// File: rtl/uart_mult_ctrl.sv
// rtl/uart_mult_ctrl.sv - UART frame sequencer driving an 8x8 multiplier core
module uart_mult_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] ERR_BYTE    = 8'hEE,
  parameter logic [7:0] MUL_TIMEOUT = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic [7:0]  o_mul_a,
  output logic [7:0]  o_mul_b,
  output logic        o_mul_start,
  input  logic        i_mul_done,
  input  logic [15:0] i_mul_product,
  output logic        o_busy,
  output logic        o_rx_overrun,
  output logic        o_frame_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_A, S_GET_B, S_MUL_GO, S_MUL_WAIT,
    S_TX_HI, S_TX_HI_WAIT, S_TX_LO, S_TX_LO_WAIT, S_TX_ERR, S_TX_ERR_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_tx_data;
  logic [7:0]  r_mul_a;
  logic [7:0]  r_mul_b;
  logic [15:0] r_prod;
  logic [7:0]  r_cnt;
  logic        r_overrun;
  logic        r_frame_err;
  logic        r_guard;     // high only in the first cycle after tx_start
  logic        r_seen_low;  // tx_ready observed low since the last tx_start

  logic w_rx_state;
  logic w_send_state;
  logic w_wait_state;
  logic w_timeout;
  logic w_wait_done;
  logic w_tx_start;
  logic w_mul_start;

  assign w_rx_state   = (r_state == S_IDLE) || (r_state == S_GET_A) || (r_state == S_GET_B);
  assign w_send_state = (r_state == S_TX_HI) || (r_state == S_TX_LO) || (r_state == S_TX_ERR);
  assign w_wait_state = (r_state == S_TX_HI_WAIT) || (r_state == S_TX_LO_WAIT) ||
                        (r_state == S_TX_ERR_WAIT);
  assign w_timeout    = (r_cnt == MUL_TIMEOUT);
  // A byte is finished once tx_ready went low and came back, ignoring the guard cycle.
  assign w_wait_done  = w_wait_state && !r_guard && r_seen_low && i_tx_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and strobe outputs
  always_comb begin
    w_next      = r_state;
    w_tx_start  = 1'b0;
    w_mul_start = 1'b0;
    case (r_state)
      S_IDLE:        if (i_rx_valid && (i_rx_data == SYNC_BYTE)) w_next = S_GET_A;
      S_GET_A:       if (i_rx_valid) w_next = S_GET_B;
      S_GET_B:       if (i_rx_valid) w_next = S_MUL_GO;
      S_MUL_GO: begin
        w_mul_start = 1'b1;
        w_next      = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        // done has priority over a coincident timeout
        if (i_mul_done)     w_next = S_TX_HI;
        else if (w_timeout) w_next = S_TX_ERR;
      end
      S_TX_HI: begin
        w_tx_start = i_tx_ready;
        if (i_tx_ready) w_next = S_TX_HI_WAIT;
      end
      S_TX_LO: begin
        w_tx_start = i_tx_ready;
        if (i_tx_ready) w_next = S_TX_LO_WAIT;
      end
      S_TX_ERR: begin
        w_tx_start = i_tx_ready;
        if (i_tx_ready) w_next = S_TX_ERR_WAIT;
      end
      S_TX_HI_WAIT:  if (w_wait_done) w_next = S_TX_LO;
      S_TX_LO_WAIT:  if (w_wait_done) w_next = S_IDLE;
      S_TX_ERR_WAIT: if (w_wait_done) w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  // Operand, product, timeout counter, tx byte and status flag registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_data   <= 8'h00;
      r_mul_a     <= 8'h00;
      r_mul_b     <= 8'h00;
      r_prod      <= 16'h0000;
      r_cnt       <= 8'h00;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_guard     <= 1'b0;
      r_seen_low  <= 1'b0;
    end else begin
      r_frame_err <= (r_state == S_IDLE) && i_rx_valid && (i_rx_data != SYNC_BYTE);
      if (i_rx_valid && !w_rx_state) r_overrun <= 1'b1;
      if ((r_state == S_GET_A) && i_rx_valid) r_mul_a <= i_rx_data;
      if ((r_state == S_GET_B) && i_rx_valid) r_mul_b <= i_rx_data;

      if (r_state == S_MUL_GO)
        r_cnt <= 8'h00;
      else if ((r_state == S_MUL_WAIT) && !i_mul_done && (r_cnt != 8'hFF))
        r_cnt <= r_cnt + 8'd1;

      // tx_data is loaded on entry to each send state and held through its wait state
      if ((r_state == S_MUL_WAIT) && i_mul_done) begin
        r_prod    <= i_mul_product;
        r_tx_data <= i_mul_product[15:8];
      end else if ((r_state == S_MUL_WAIT) && w_timeout) begin
        r_tx_data <= ERR_BYTE;
      end else if ((r_state == S_TX_HI_WAIT) && w_wait_done) begin
        r_tx_data <= r_prod[7:0];
      end

      r_guard <= w_tx_start;
      if (w_tx_start)
        r_seen_low <= 1'b0;
      else if (w_wait_state && !r_guard && !i_tx_ready)
        r_seen_low <= 1'b1;
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_tx_start   = w_tx_start;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_mul_start  = w_mul_start;
  assign o_busy       = (r_state != S_IDLE);
  assign o_rx_overrun = r_overrun;
  assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_mult_ctrl.sv
// tb/tb_uart_mult_ctrl.sv - randomized self-checking bench for uart_mult_ctrl
module tb_uart_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_start;
  logic        mul_done;
  logic [15:0] mul_product;
  logic        busy;
  logic        rx_overrun;
  logic        frame_err;

  int passed = 0;
  int total  = 0;

  uart_mult_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_tx_ready(tx_ready), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_start(mul_start),
    .i_mul_done(mul_done), .i_mul_product(mul_product), .o_busy(busy),
    .o_rx_overrun(rx_overrun), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation of DUT strobes, sampled on the falling edge
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  int         tx_seen = 0;
  int         mul_start_n = 0;
  int         mul_start_cyc = 0;
  logic [7:0] cap_a = 8'h00;
  logic [7:0] cap_b = 8'h00;
  int         ferr_n = 0;
  int         viol_n = 0;
  logic [7:0] tx_hold_byte = 8'h00;
  logic       prev_tx = 1'b0;
  logic       prev_mul = 1'b0;
  int         tx_busy_cnt = 0;
  logic       tx_hold = 1'b0;
  int         tx_done_n = 0;

  always @(negedge clk) begin
    if (tx_busy_cnt > 0 && busy && tx_data !== tx_hold_byte) viol_n++;
    if (tx_start) begin
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
      tx_seen++;
      tx_hold_byte = tx_data;
    end
    if (mul_start) begin
      mul_start_n++;
      mul_start_cyc = cyc;
      cap_a = mul_a;
      cap_b = mul_b;
    end
    if (frame_err) ferr_n++;
    if (tx_start && mul_start) viol_n++;
    if ((tx_start && prev_tx) || (mul_start && prev_mul)) viol_n++;
    prev_tx  = tx_start;
    prev_mul = mul_start;
  end

  // Transmitter model: ready drops for a few cycles after each accepted byte
  always @(posedge clk) begin
    #1;
    if (tx_seen != tx_done_n) begin
      tx_done_n   = tx_seen;
      tx_busy_cnt = $urandom_range(2, 5);
    end else if (tx_busy_cnt > 0) begin
      tx_busy_cnt--;
    end
    tx_ready = !tx_hold && (tx_busy_cnt == 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Runs one frame and reports what was observed; callers do the comparisons.
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input int delay,
                          input int hold, input bit extra, output bit ok,
                          output int start_lat, output int done_lat, output int nbytes,
                          output int during_hold, output logic [7:0] ga,
                          output logic [7:0] gb, output logic [7:0] hi, output logic [7:0] lo);
    int base, n0, cb, cd;
    bit got_start;
    base = tx_q.size();
    n0 = mul_start_n;
    ok = 1'b0; start_lat = -1; done_lat = -1; during_hold = -1;
    hi = 8'hxx; lo = 8'hxx; ga = 8'hxx; gb = 8'hxx;
    send_byte(8'hA5);
    send_byte(a);
    cb = cyc;
    send_byte(b);
    got_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mul_start_n > n0) begin
        got_start = 1'b1;
        break;
      end
      tick();
    end
    if (got_start) begin
      start_lat = mul_start_cyc - cb;
      ga = cap_a;
      gb = cap_b;
      if (extra) send_byte(8'h55);
      tick(delay);
      if (hold > 0) tx_hold = 1'b1;
      mul_product = 16'(a) * 16'(b);
      mul_done = 1'b1;
      cd = cyc;
      tick();
      mul_done = 1'b0;
      mul_product = 16'h0000;
      if (hold > 0) begin
        tick(hold);
        during_hold = tx_q.size() - base;
        tx_hold = 1'b0;
      end
      for (int i = 0; i < 2000; i++) begin
        if (tx_q.size() >= base + 2 && !busy) break;
        tick();
      end
      ok = (tx_q.size() >= base + 2) && !busy;
      tick(3);
      if (tx_q.size() > base) done_lat = tx_cyc_q[base] - cd;
    end
    nbytes = tx_q.size() - base;
    if (nbytes >= 1) hi = tx_q[base];
    if (nbytes >= 2) lo = tx_q[base + 1];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if ({tx_start, mul_start, rx_overrun, frame_err} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {tx_start, mul_start, rx_overrun, frame_err});
    else passed++;
    total++; if ({tx_data, mul_a, mul_b} !== 24'h0)
      $display("FAIL reset_data: got %h expected 000000", {tx_data, mul_a, mul_b});
    else passed++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                            input int delay);
    bit ok; int sl, dl, nb, dh; logic [7:0] ga, gb, hi, lo;
    logic [15:0] exp;
    int n0;
    n0 = mul_start_n;
    exp = 16'(a) * 16'(b);
    do_frame(a, b, delay, 0, 1'b0, ok, sl, dl, nb, dh, ga, gb, hi, lo);
    total++; if (ok !== 1'b1) $display("FAIL %s_complete: got %b expected 1", name, ok); else passed++;
    total++; if ({ga, gb} !== {a, b})
      $display("FAIL %s_operands: got %h expected %h", name, {ga, gb}, {a, b});
    else passed++;
    total++; if (mul_start_n - n0 != 1)
      $display("FAIL %s_start_count: got %0d expected 1", name, mul_start_n - n0);
    else passed++;
    total++; if (nb != 2) $display("FAIL %s_byte_count: got %0d expected 2", name, nb); else passed++;
    total++; if ({hi, lo} !== exp)
      $display("FAIL %s_product: got %h expected %h", name, {hi, lo}, exp);
    else passed++;
    total++; if (sl != 1) $display("FAIL %s_start_latency: got %0d expected 1", name, sl); else passed++;
    total++; if (dl != 1) $display("FAIL %s_done_latency: got %0d expected 1", name, dl); else passed++;
  endtask

  task automatic test_basic;
    test_frame("basic", 8'h0C, 8'h0D, 3);
  endtask

  task automatic test_max_operands;
    test_frame("max", 8'hFF, 8'hFF, 2);
  endtask

  task automatic test_bad_header;
    int f0, n0;
    f0 = ferr_n;
    n0 = mul_start_n;
    send_byte(8'h3C);
    tick(3);
    total++; if (ferr_n - f0 != 1) $display("FAIL bad_hdr_frame_err: got %0d expected 1", ferr_n - f0);
    else passed++;
    total++; if (mul_start_n != n0) $display("FAIL bad_hdr_mul_start: got %0d expected %0d", mul_start_n, n0);
    else passed++;
    total++; if (busy !== 1'b0) $display("FAIL bad_hdr_busy: got %b expected 0", busy); else passed++;
    test_frame("after_bad_hdr", 8'h02, 8'h03, 1);
  endtask

  task automatic test_random_frames;
    for (int k = 0; k < 8; k++)
      test_frame($sformatf("rand%0d", k), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), $urandom_range(1, 20));
  endtask

  task automatic test_timeout;
    int base, n0, t0;
    bit got;
    base = tx_q.size();
    n0 = mul_start_n;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_q.size() > base && !busy) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    tick(3);
    total++; if (got !== 1'b1) $display("FAIL timeout_complete: got %b expected 1", got); else passed++;
    total++; if (tx_q.size() - base != 1)
      $display("FAIL timeout_byte_count: got %0d expected 1", tx_q.size() - base);
    else passed++;
    if (tx_q.size() > base) begin
      t0 = tx_cyc_q[base] - mul_start_cyc;
      total++; if (tx_q[base] !== 8'hEE) $display("FAIL timeout_byte: got %h expected ee", tx_q[base]);
      else passed++;
      total++; if (t0 != 257) $display("FAIL timeout_latency: got %0d expected 257", t0); else passed++;
    end
    total++; if (mul_start_n - n0 != 1)
      $display("FAIL timeout_start_count: got %0d expected 1", mul_start_n - n0);
    else passed++;
    test_frame("after_timeout", 8'h07, 8'h09, 4);
  endtask

  task automatic test_overrun_backpressure;
    bit ok; int sl, dl, nb, dh; logic [7:0] ga, gb, hi, lo;
    logic [7:0] a, b;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    total++; if (rx_overrun !== 1'b0) $display("FAIL overrun_pre: got %b expected 0", rx_overrun);
    else passed++;
    do_frame(a, b, 5, 50, 1'b1, ok, sl, dl, nb, dh, ga, gb, hi, lo);
    total++; if (ok !== 1'b1) $display("FAIL bp_complete: got %b expected 1", ok); else passed++;
    total++; if (dh != 0) $display("FAIL bp_withheld: got %0d bytes expected 0", dh); else passed++;
    total++; if ({hi, lo} !== 16'(a) * 16'(b))
      $display("FAIL bp_product: got %h expected %h", {hi, lo}, 16'(a) * 16'(b));
    else passed++;
    total++; if (rx_overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", rx_overrun);
    else passed++;
    tick(5);
    total++; if (rx_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", rx_overrun);
    else passed++;
  endtask

  task automatic test_reset_mid_tx;
    int base;
    bit got;
    base = tx_q.size();
    send_byte(8'hA5);
    send_byte(8'h34);
    send_byte(8'h56);
    tick(2);
    mul_product = 16'h34 * 16'h56;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_q.size() >= base + 2) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    total++; if (got !== 1'b1) $display("FAIL rst_mid_reach: got %b expected 1", got); else passed++;
    tick();
    total++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b expected 1", busy); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({busy, tx_start, mul_start, rx_overrun, frame_err} !== 5'b0)
      $display("FAIL rst_mid_flags: got %b expected 00000", {busy, tx_start, mul_start, rx_overrun, frame_err});
    else passed++;
    total++; if ({tx_data, mul_a, mul_b} !== 24'h0)
      $display("FAIL rst_mid_data: got %h expected 000000", {tx_data, mul_a, mul_b});
    else passed++;
    tick(10);
    test_frame("after_rst", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 6);
  endtask

  task automatic test_protocol;
    total++; if (viol_n != 0) $display("FAIL strobe_protocol: got %0d violations expected 0", viol_n);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    mul_done = 1'b0;
    mul_product = 16'h0000;
    test_reset();
    test_basic();
    test_max_operands();
    test_bad_header();
    test_random_frames();
    test_timeout();
    test_overrun_backpressure();
    test_reset_mid_tx();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
